greyscale_line_buffer: RTL and testbench



---
 rtl/camera_pkg.sv | 11 +
 rtl/Line_Buffer2.sv | 38 +++
 rtl/greyscale_line_buffer.sv | 93 +++++++++
 tb/tb_greyscale_line_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared camera-pipeline types and geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package camera_pkg;

   localparam int DATA_W    = 12;
   localparam int RAW_WIDTH = 1280;

   typedef logic [11:0] pixel_t;

endpackage

// File: rtl/Line_Buffer2.sv
// Tapped shift-register line buffer, RAW_WIDTH+2 entries deep, no reset on storage.
// Latency: taps are combinational reads; taps0x is the sample from RAW_WIDTH enabled shifts ago.
// Backpressure: none; clken=0 freezes the whole chain.
module Line_Buffer2 #(
   parameter int DATA_W    = camera_pkg::DATA_W,
   parameter int RAW_WIDTH = camera_pkg::RAW_WIDTH
) (
   input  logic              clock,
   input  logic              clken,
   input  logic [DATA_W-1:0] shiftin,
   output logic [DATA_W-1:0] shiftout,
   output logic [DATA_W-1:0] taps0x,
   output logic [DATA_W-1:0] taps1x,
   output logic [DATA_W-1:0] taps2x
);

   localparam int DEPTH = RAW_WIDTH + 2;

   // entry 0 holds the newest sample, entry k the sample from k+1 shifts ago
   logic [DATA_W-1:0] sr_q [DEPTH];

   // advance the chain only on enabled edges; storage is deliberately reset-free
   always_ff @(posedge clock) begin
      if (clken) begin
         sr_q[0] <= shiftin;
         for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
         end
      end
   end

   assign taps0x   = sr_q[RAW_WIDTH-1];
   assign taps1x   = sr_q[RAW_WIDTH];
   assign taps2x   = sr_q[RAW_WIDTH+1];
   // cascaded instances chain off the same-column tap so they stay aligned
   assign shiftout = taps0x;

endmodule

// File: rtl/greyscale_line_buffer.sv
// Averages each 2x2 Bayer quad (R,G1,G2,B) into one grey sample using a one-line buffer.
// Latency: oGrey/oDVAL update on the edge that samples the quad's last pixel (1 cycle).
// Backpressure: none; every oDVAL strobe must be accepted downstream.
module greyscale_line_buffer #(
   parameter int RAW_WIDTH = camera_pkg::RAW_WIDTH,
   parameter int DATA_W    = camera_pkg::DATA_W
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic [DATA_W-1:0] iDATA,
   input  logic              iDVAL,
   input  logic [10:0]       iX_Cont,
   input  logic [10:0]       iY_Cont,
   output logic [DATA_W-1:0] oGrey,
   output logic              oDVAL
);

   import camera_pkg::*;

   localparam int SUM_W = DATA_W + 2;

   logic [DATA_W-1:0] tap_up;      // same column, previous line
   logic [DATA_W-1:0] lb_shiftout;
   logic [DATA_W-1:0] lb_taps1x;
   logic [DATA_W-1:0] lb_taps2x;

   logic [DATA_W-1:0] cur_q;       // previous valid pixel on this line (column x-1)
   logic [DATA_W-1:0] up_q;        // previous line, column x-1
   logic [DATA_W-1:0] grey_q, grey_d;
   logic              dval_q, dval_d;

   logic              quad_done;
   logic [SUM_W-1:0]  quad_sum;

   Line_Buffer2 #(
      .DATA_W    (DATA_W),
      .RAW_WIDTH (RAW_WIDTH)
   ) u_line_buffer (
      .clock    (iCLK),
      .clken    (iDVAL),
      .shiftin  (iDATA),
      .shiftout (lb_shiftout),
      .taps0x   (tap_up),
      .taps1x   (lb_taps1x),
      .taps2x   (lb_taps2x)
   );

   // only the parity bits of the counters matter here; the other taps serve the edge stage
   logic lb_unused;
   assign lb_unused = ^{lb_shiftout, lb_taps1x, lb_taps2x, iX_Cont[10:1], iY_Cont[10:1]};

   // the quad closes on the odd column of an odd row
   assign quad_done = iDVAL & iX_Cont[0] & iY_Cont[0];

   // four 12-bit terms cannot overflow 14 bits
   assign quad_sum = SUM_W'(iDATA) + SUM_W'(cur_q) + SUM_W'(tap_up) + SUM_W'(up_q);

   // next output: new average on quad completion, otherwise hold the sample and drop the strobe
   always_comb begin
      grey_d = grey_q;
      dval_d = 1'b0;
      if (quad_done) begin
         grey_d = quad_sum[SUM_W-1:2];
         dval_d = 1'b1;
      end
   end

   // capture the left-hand column of the quad; invalid cycles leave it untouched
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         cur_q <= '0;
         up_q  <= '0;
      end else if (iDVAL) begin
         cur_q <= iDATA;
         up_q  <= tap_up;
      end
   end

   // output register
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         grey_q <= '0;
         dval_q <= 1'b0;
      end else begin
         grey_q <= grey_d;
         dval_q <= dval_d;
      end
   end

   assign oGrey = grey_q;
   assign oDVAL = dval_q;

endmodule

// File: tb/tb_greyscale_line_buffer.sv
// Directed bench for greyscale_line_buffer with a frame-memory scoreboard (RAW_WIDTH=8).
// Latency: expects each strobe one cycle after the completing pixel is sampled.
// Backpressure: none; every strobe is popped against the scoreboard.
module tb_greyscale_line_buffer;

   localparam int RW   = 8;
   localparam int ROWS = 4;
   localparam int DW   = 12;

   logic          iCLK;
   logic          iRST;
   logic [DW-1:0] iDATA;
   logic          iDVAL;
   logic [10:0]   iX_Cont;
   logic [10:0]   iY_Cont;
   logic [DW-1:0] oGrey;
   logic          oDVAL;

   logic          lb_en;
   logic [DW-1:0] lb_in;
   logic [DW-1:0] lb_out, lb_t0, lb_t1, lb_t2;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] sb[$];
   logic [DW-1:0] pix [ROWS][RW];
   int            strobes;
   logic          mon_en;
   logic          exp_dval;
   logic          prev_dval;

   greyscale_line_buffer #(
      .RAW_WIDTH (RW),
      .DATA_W    (DW)
   ) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iDATA   (iDATA),
      .iDVAL   (iDVAL),
      .iX_Cont (iX_Cont),
      .iY_Cont (iY_Cont),
      .oGrey   (oGrey),
      .oDVAL   (oDVAL)
   );

   Line_Buffer2 #(
      .DATA_W    (DW),
      .RAW_WIDTH (RW)
   ) u_lb (
      .clock    (iCLK),
      .clken    (lb_en),
      .shiftin  (lb_in),
      .shiftout (lb_out),
      .taps0x   (lb_t0),
      .taps1x   (lb_t1),
      .taps2x   (lb_t2)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // what the strobe should be one cycle after this edge
   always @(posedge iCLK) begin
      exp_dval = iRST && iDVAL && iX_Cont[0] && iY_Cont[0];
   end

   // output monitor: strobe timing, spacing and scoreboard values
   always @(negedge iCLK) begin
      if (mon_en) begin
         chk("dval", {31'b0, oDVAL}, {31'b0, exp_dval});
         chk("spacing", {31'b0, oDVAL & prev_dval}, 32'd0);
         prev_dval = oDVAL;
         if (oDVAL) begin
            strobes++;
            chk("sb_avail", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               logic [DW-1:0] e;
               e = sb.pop_front();
               chk("grey", {20'b0, oGrey}, {20'b0, e});
            end
         end
      end
   end

   task automatic idle_cycle();
      @(posedge iCLK);
      #1;
      iDVAL   = 1'b0;
      iDATA   = DW'($urandom);
      iX_Cont = 11'($urandom);
      iY_Cont = 11'($urandom);
   endtask

   task automatic send(input int x, input int y, input logic [DW-1:0] d);
      int s;
      @(posedge iCLK);
      #1;
      iDVAL   = 1'b1;
      iDATA   = d;
      iX_Cont = 11'(x);
      iY_Cont = 11'(y);
      pix[y][x] = d;
      if ((x % 2 == 1) && (y % 2 == 1)) begin
         s = int'(pix[y-1][x-1]) + int'(pix[y-1][x]) + int'(pix[y][x-1]) + int'(pix[y][x]);
         sb.push_back(DW'(s / 4));
      end
   endtask

   // mode: 0 constant 800, 1 random, 2 quad pattern R/G1/G2/B = 4/5/6/7, 3 all FFF
   task automatic drive_frame(input int mode, input bit gaps);
      logic [DW-1:0] d;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < RW; x++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
               int n;
               n = int'($urandom_range(1, 3));
               for (int k = 0; k < n; k++) idle_cycle();
            end
            case (mode)
               0:       d = 12'h800;
               1:       d = DW'($urandom);
               2:       d = DW'(4 + 2 * (y % 2) + (x % 2));
               default: d = 12'hFFF;
            endcase
            send(x, y, d);
         end
      end
      for (int k = 0; k < 3; k++) idle_cycle();
      @(negedge iCLK);
      chk("frame_strobes", 32'(strobes), 32'((ROWS / 2) * (RW / 2)));
      strobes = 0;
   endtask

   initial begin
      iRST      = 1'b0;
      iDVAL     = 1'b0;
      iDATA     = '0;
      iX_Cont   = '0;
      iY_Cont   = '0;
      lb_en     = 1'b0;
      lb_in     = '0;
      mon_en    = 1'b0;
      prev_dval = 1'b0;
      exp_dval  = 1'b0;
      strobes   = 0;

      // standalone line buffer: ramp, then hold with clken low
      for (int n = 1; n <= 20; n++) begin
         lb_en = 1'b1;
         lb_in = DW'(n - 1);
         @(posedge iCLK);
         #1;
         if (n >= 10) begin
            chk("lb_t0", {20'b0, lb_t0}, 32'(n - 8));
            chk("lb_t1", {20'b0, lb_t1}, 32'(n - 9));
            chk("lb_t2", {20'b0, lb_t2}, 32'(n - 10));
            chk("lb_out", {20'b0, lb_out}, 32'(n - 8));
         end
      end
      lb_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         lb_in = DW'($urandom);
         @(posedge iCLK);
         #1;
         chk("lb_hold_t0", {20'b0, lb_t0}, 32'd12);
         chk("lb_hold_t2", {20'b0, lb_t2}, 32'd10);
      end

      // held in reset with random inputs
      for (int k = 0; k < 8; k++) begin
         @(posedge iCLK);
         #1;
         iDVAL   = 1'($urandom);
         iDATA   = DW'($urandom);
         iX_Cont = 11'($urandom);
         iY_Cont = 11'($urandom);
         @(negedge iCLK);
         chk("rst_grey", {20'b0, oGrey}, 32'd0);
         chk("rst_dval", {31'b0, oDVAL}, 32'd0);
      end
      @(posedge iCLK);
      #1;
      iDVAL = 1'b0;
      iRST  = 1'b1;
      mon_en = 1'b1;

      drive_frame(0, 1'b0);
      drive_frame(0, 1'b1);
      drive_frame(2, 1'b0);
      chk("quad_avg_5", {20'b0, oGrey}, 32'd5);
      drive_frame(3, 1'b0);
      chk("quad_fff", {20'b0, oGrey}, 32'hFFF);

      // asynchronous reset between edges clears the outputs at once
      @(posedge iCLK);
      #1;
      mon_en = 1'b0;
      #2;
      iRST = 1'b0;
      #1;
      chk("arst_grey", {20'b0, oGrey}, 32'd0);
      chk("arst_dval", {31'b0, oDVAL}, 32'd0);
      @(posedge iCLK);
      #1;
      iRST      = 1'b1;
      prev_dval = 1'b0;
      mon_en    = 1'b1;

      drive_frame(1, 1'b0);
      drive_frame(1, 1'b1);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
